// File: rtl/fp_div_pkg.sv
// Shared types, constants and IEEE-754 single field helpers for the divider issuer.
package fp_div_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

   localparam logic [31:0] QNAN      = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF   = 32'h7F80_0000;
   localparam logic [31:0] SIGN_MASK = 32'h8000_0000;

   function automatic logic sign_of(input logic [31:0] x);
      return x[31];
   endfunction

   function automatic logic [7:0] exp_of(input logic [31:0] x);
      return x[30:23];
   endfunction

   function automatic logic [22:0] man_of(input logic [31:0] x);
      return x[22:0];
   endfunction

endpackage

// File: rtl/fp_special_classifier.sv
// Combinational detector for divide operand pairs whose quotient is known
// without running the Divider (NaN, zero and infinity cases).
module fp_special_classifier
   import fp_div_pkg::*;
#(
   parameter logic [31:0] NAN_VAL = 32'h7FC0_0000
) (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        is_special,
   output logic [31:0] result,
   output logic        nan
);

   logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;

   // Operand classes; denormals are treated as finite non-zero values
   always_comb begin
      a_nan  = (exp_of(a) == 8'hFF) && (man_of(a) != 23'd0);
      b_nan  = (exp_of(b) == 8'hFF) && (man_of(b) != 23'd0);
      a_inf  = (exp_of(a) == 8'hFF) && (man_of(a) == 23'd0);
      b_inf  = (exp_of(b) == 8'hFF) && (man_of(b) == 23'd0);
      a_zero = (exp_of(a) == 8'h00) && (man_of(a) == 23'd0);
      b_zero = (exp_of(b) == 8'h00) && (man_of(b) == 23'd0);
      sgn    = sign_of(a) ^ sign_of(b);
   end

   // Priority: invalid ops first, then infinite results, then zero results
   always_comb begin
      is_special = 1'b0;
      result     = '0;
      nan        = 1'b0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         is_special = 1'b1;
         result     = NAN_VAL;
         nan        = 1'b1;
      end else if (b_zero || a_inf) begin
         is_special = 1'b1;
         result     = POS_INF | (sgn ? SIGN_MASK : 32'h0);
      end else if (a_zero || b_inf) begin
         is_special = 1'b1;
         result     = sgn ? SIGN_MASK : 32'h0;
      end
   end

endmodule

// File: rtl/fp_div_issuer.sv
// Initiator for the Divider En/Ready handshake: takes operand pairs on a
// valid/ready stream, pulses En, waits for a Ready or NaN rising edge (or
// times out) and returns the quotient on a valid/ready stream.
// Optional build macro: FP_DIV_ISSUER_BYPASS_EN (special operands skip the Divider).
module fp_div_issuer #(
   parameter int unsigned EN_PULSE_CYCLES = 2,
   parameter int unsigned TIMEOUT_CYCLES  = 64,
   parameter logic [31:0] QNAN            = 32'h7FC0_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   output logic        div_en,
   input  logic [31:0] div_result,
   input  logic        div_ready,
   input  logic        div_nan,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_nan,
   output logic        out_timeout,
   output logic        busy
);
   import fp_div_pkg::*;

   localparam int unsigned PCW = 4;
   localparam int unsigned WCW = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned DCW = 8;

   state_t           state, state_d;
   logic [31:0]      div_a_d, div_b_d, out_result_d, pend_res, pend_res_d;
   logic             div_en_d, out_valid_d, out_nan_d, out_timeout_d;
   logic [PCW-1:0]   pulse_cnt, pulse_cnt_d;
   logic [WCW-1:0]   wait_cnt, wait_cnt_d;
   logic [DCW-1:0]   ign_cnt, ign_cnt_d;
   logic             ready_q, nan_q, pend, pend_d, pend_nan, pend_nan_d;
   logic             comp;
   logic [31:0]      comp_res;

`ifdef FP_DIV_ISSUER_BYPASS_EN
   logic             sp_special;
   logic [31:0]      sp_result;
   logic             sp_nan;

   fp_special_classifier #(.NAN_VAL(QNAN)) u_classifier (
      .a          (in_a),
      .b          (in_b),
      .is_special (sp_special),
      .result     (sp_result),
      .nan        (sp_nan)
   );
`endif

   // Completion is edge-only so a level left over from the previous op is ignored
   always_comb begin
      comp     = (div_ready & ~ready_q) | (div_nan & ~nan_q);
      comp_res = div_nan ? QNAN : div_result;
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // Next-state and registered-output computation
   always_comb begin
      state_d       = state;
      div_a_d       = div_a;
      div_b_d       = div_b;
      div_en_d      = div_en;
      pulse_cnt_d   = pulse_cnt;
      wait_cnt_d    = wait_cnt;
      out_valid_d   = out_valid;
      out_result_d  = out_result;
      out_nan_d     = out_nan;
      out_timeout_d = out_timeout;
      pend_d        = pend;
      pend_res_d    = pend_res;
      pend_nan_d    = pend_nan;
      ign_cnt_d     = ign_cnt;
      case (state)
         IDLE: begin
            if (comp) ign_cnt_d = ign_cnt + DCW'(1);
            if (in_valid) begin
               div_a_d     = in_a;
               div_b_d     = in_b;
               pulse_cnt_d = '0;
               pend_d      = 1'b0;
`ifdef FP_DIV_ISSUER_BYPASS_EN
               if (sp_special) begin
                  out_valid_d   = 1'b1;
                  out_result_d  = sp_result;
                  out_nan_d     = sp_nan;
                  out_timeout_d = 1'b0;
                  state_d       = OUT;
               end else begin
                  div_en_d = 1'b1;
                  state_d  = ISSUE;
               end
`else
               div_en_d = 1'b1;
               state_d  = ISSUE;
`endif
            end
         end
         ISSUE: begin
            pulse_cnt_d = pulse_cnt + PCW'(1);
            if (comp && !pend) begin
               pend_d     = 1'b1;
               pend_res_d = comp_res;
               pend_nan_d = div_nan;
            end
            if (pulse_cnt == PCW'(EN_PULSE_CYCLES - 1)) begin
               div_en_d   = 1'b0;
               wait_cnt_d = '0;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            wait_cnt_d = wait_cnt + WCW'(1);
            if (pend || comp) begin
               out_valid_d   = 1'b1;
               out_result_d  = pend ? pend_res : comp_res;
               out_nan_d     = pend ? pend_nan : div_nan;
               out_timeout_d = 1'b0;
               pend_d        = 1'b0;
               state_d       = OUT;
            end else if (wait_cnt == WCW'(TIMEOUT_CYCLES - 1)) begin
               out_valid_d   = 1'b1;
               out_result_d  = QNAN;
               out_nan_d     = 1'b1;
               out_timeout_d = 1'b1;
               state_d       = OUT;
            end
         end
         OUT: begin
            if (comp) ign_cnt_d = ign_cnt + DCW'(1);
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset discards any in-flight op
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         div_a       <= '0;
         div_b       <= '0;
         div_en      <= 1'b0;
         pulse_cnt   <= '0;
         wait_cnt    <= '0;
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_nan     <= 1'b0;
         out_timeout <= 1'b0;
         ready_q     <= 1'b0;
         nan_q       <= 1'b0;
         pend        <= 1'b0;
         pend_res    <= '0;
         pend_nan    <= 1'b0;
         ign_cnt     <= '0;
      end else begin
         state       <= state_d;
         div_a       <= div_a_d;
         div_b       <= div_b_d;
         div_en      <= div_en_d;
         pulse_cnt   <= pulse_cnt_d;
         wait_cnt    <= wait_cnt_d;
         out_valid   <= out_valid_d;
         out_result  <= out_result_d;
         out_nan     <= out_nan_d;
         out_timeout <= out_timeout_d;
         ready_q     <= div_ready;
         nan_q       <= div_nan;
         pend        <= pend_d;
         pend_res    <= pend_res_d;
         pend_nan    <= pend_nan_d;
         ign_cnt     <= ign_cnt_d;
      end
   end

endmodule

// File: tb/tb_fp_div_issuer.sv
// Scoreboard bench for fp_div_issuer with a behavioural Divider model.
module tb_fp_div_issuer;

   localparam int unsigned EN_P = 2;
   localparam int unsigned TO   = 64;
   localparam int          LAT  = 10;

   typedef struct packed {
      logic [31:0] res;
      logic        nan;
      logic        to;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_a, in_b, div_a, div_b, div_result, out_result;
   logic        div_en, div_ready, div_nan, out_nan, out_timeout, busy;

   int   n_cmp = 0;
   int   n_mis = 0;
   exp_t sb_q[$];

   // Model modes: 0 Ready pulse, 1 NaN pulse, 2 silent, 3 Ready left high
   int   mdl_mode;
   int   mdl_cnt;
   logic en_q;

   always #5 clk = ~clk;

   fp_div_issuer #(
      .EN_PULSE_CYCLES (EN_P),
      .TIMEOUT_CYCLES  (TO),
      .QNAN            (32'h7FC0_0000)
   ) dut (
      .clk         (clk),
      .reset       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .div_a       (div_a),
      .div_b       (div_b),
      .div_en      (div_en),
      .div_result  (div_result),
      .div_ready   (div_ready),
      .div_nan     (div_nan),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_nan     (out_nan),
      .out_timeout (out_timeout),
      .busy        (busy)
   );

   function automatic logic [31:0] mdl_quot(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] k;
      k = {a, b};
      case (k)
         {32'h4000_0000, 32'h3F80_0000}: return 32'h4000_0000;
         {32'h4070_0000, 32'h3FC0_0000}: return 32'h4020_0000;
         {32'h3F80_0000, 32'h3F80_0000}: return 32'h3F80_0000;
         default:                        return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Behavioural Divider: responds about LAT cycles after the En rising edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q       <= 1'b0;
         mdl_cnt    <= -1;
         div_ready  <= 1'b0;
         div_nan    <= 1'b0;
         div_result <= '0;
      end else begin
         en_q    <= div_en;
         div_nan <= 1'b0;
         if (mdl_mode != 3) div_ready <= 1'b0;
         if (div_en && !en_q) begin
            if (mdl_mode != 2) mdl_cnt <= LAT - 1;
         end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
         end else if (mdl_cnt == 0) begin
            if (mdl_mode == 1) begin
               div_nan <= 1'b1;
               mdl_cnt <= -1;
            end else if (div_ready) begin
               div_ready <= 1'b0;
            end else begin
               div_ready  <= 1'b1;
               div_result <= mdl_quot(div_a, div_b);
               mdl_cnt    <= -1;
            end
         end
      end
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, output bit ok);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      ok = in_ready;
      if (!ok) begin
         check_val("issue_wait", 64'd0, 64'd1);
         return;
      end
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic collect(input int exp_en, input int hold, output int lat, output int gap);
      int          en_cyc, fall_at, n;
      logic        prev_en;
      logic [31:0] r0;
      exp_t        e;
      n       = 1;
      en_cyc  = div_en ? 1 : 0;
      prev_en = div_en;
      fall_at = -1;
      while (!out_valid && n < 400) begin
         tick();
         n++;
         if (div_en) en_cyc++;
         if (prev_en && !div_en) fall_at = n;
         prev_en = div_en;
      end
      lat = n;
      gap = n - fall_at;
      if (!out_valid) begin
         check_val("out_valid_wait", 64'd0, 64'd1);
         if (sb_q.size() > 0) sb_q.delete(0);
         return;
      end
      check_val("en_cycles", 64'(en_cyc), 64'(exp_en));
      r0 = out_result;
      for (int i = 0; i < hold; i++) begin
         tick();
         check_val("hold_valid", 64'(out_valid), 64'd1);
         check_val("hold_result", 64'(out_result), 64'(r0));
         check_val("hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check_val("out_result", 64'(out_result), 64'(e.res));
         check_val("out_nan", 64'(out_nan), 64'(e.nan));
         check_val("out_timeout", 64'(out_timeout), 64'(e.to));
      end
      check_val("in_ready_in_out", 64'(in_ready), 64'd0);
      tick();
      out_ready = 1'b0;
      check_val("valid_dropped", 64'(out_valid), 64'd0);
      check_val("in_ready_after", 64'(in_ready), 64'd1);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                         input logic nan, input logic to, input int exp_en, input int hold,
                         output int lat, output int gap);
      bit   ok;
      exp_t e;
      lat = 0;
      gap = 0;
      issue(a, b, ok);
      if (!ok) return;
      e.res = res;
      e.nan = nan;
      e.to  = to;
      sb_q.push_back(e);
      collect(exp_en, hold, lat, gap);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat, gap, nan_en;
      bit  ok;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_a      = '0;
      in_b      = '0;
      mdl_mode  = 0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_in_ready", 64'(in_ready), 64'd1);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_div_en", 64'(div_en), 64'd0);
      check_val("rst_div_a", 64'(div_a), 64'd0);
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_out_result", 64'(out_result), 64'd0);
      rst_n = 1'b1;
      tick();

      // Plain divide through the Divider
      run_op(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, EN_P, 0, lat, gap);

      // Downstream back-pressure for 5 cycles
      run_op(32'h4070_0000, 32'h3FC0_0000, 32'h4020_0000, 1'b0, 1'b0, EN_P, 5, lat, gap);

      // 0/0 with NaN reported without Ready
      mdl_mode = 1;
`ifdef FP_DIV_ISSUER_BYPASS_EN
      nan_en = 0;
`else
      nan_en = EN_P;
`endif
      run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1, 1'b0, nan_en, 0, lat, gap);

      // Silent Divider: timeout exactly TO cycles after En falls
      mdl_mode = 2;
      run_op(32'h3F80_0000, 32'h4000_0000, 32'h7FC0_0000, 1'b1, 1'b1, EN_P, 0, lat, gap);
      check_val("timeout_gap", 64'(gap), 64'(TO));

      // Ready left high by the previous op must not complete the next one
      mdl_mode = 3;
      run_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, EN_P, 0, lat, gap);
      run_op(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, EN_P, 0, lat, gap);
      check_val("stale_ready_lat", 64'(lat > LAT), 64'd1);
      mdl_mode = 0;
      repeat (2) tick();

      // Reset while waiting on the Divider
      mdl_mode = 2;
      issue(32'h4000_0000, 32'h3F80_0000, ok);
      repeat (6) tick();
      check_val("pre_rst_busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("mid_rst_div_en", 64'(div_en), 64'd0);
      check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check_val("mid_rst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      mdl_mode = 0;
      tick();
      run_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, EN_P, 0, lat, gap);

`ifdef FP_DIV_ISSUER_BYPASS_EN
      // Special operands bypass the Divider
      run_op(32'h40A0_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b0, 0, 0, lat, gap);
      run_op(32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0, 1'b0, 0, 0, lat, gap);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/fp_div_issuer.md
Name: fp_div_issuer

Overview:
Initiator side of the Divider En/Ready handshake. Accepts operand pairs on a valid/ready input stream and drives A/B/En to the Divider. Waits for completion, reported either by Ready or by NaN, which can arrive without Ready. Returns the result on a valid/ready output stream, with a timeout guard against a hung divider. Sits between the FPU op dispatcher and the Divider instance.

Parameters:
- EN_PULSE_CYCLES, 2: cycles div_en is held high per issue (1..15).
- TIMEOUT_CYCLES, 64: wait cycles after the En pulse before the op is abandoned (≥4).
- QNAN, 32'h7FC00000: canonical NaN returned on NaN or timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  issuer can accept an operand pair.
- in_a  in  32  dividend, IEEE-754 single.
- in_b  in  32  divisor, IEEE-754 single.
- div_a  out  32  to Divider A.
- div_b  out  32  to Divider B.
- div_en  out  1  to Divider En.
- div_result  in  32  from Divider Result.
- div_ready  in  1  from Divider Ready.
- div_nan  in  1  from Divider NaN.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  32  quotient.
- out_nan  out  1  result is NaN.
- out_timeout  out  1  op abandoned by timeout; out_result = QNAN.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE. div_en=0; div_a=div_b=0. in_ready=1 is combinational and follows IDLE. out_valid=0, out_result=0, out_nan=0, out_timeout=0. Counters=0. ready_q=nan_q=0.
- ready_q and nan_q register div_ready and div_nan every cycle. Completion is a rising edge only: (div_ready & ~ready_q) | (div_nan & ~nan_q). This prevents a Ready left high by the previous op from completing a new one.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a/in_b into div_a/div_b, set div_en=1, clear pulse_cnt, go to ISSUE.
- ISSUE:
  - div_en stays high for exactly EN_PULSE_CYCLES cycles, then drops to 0 and the FSM goes to WAIT with wait_cnt=0.
  - div_a/div_b stay stable from IDLE exit until return to IDLE.
  - A completion edge during ISSUE is captured and honoured at WAIT entry. It is not lost.
- WAIT:
  - wait_cnt increments every cycle.
  - On completion: out_result = div_nan ? QNAN : div_result; out_nan = div_nan; out_timeout=0; out_valid=1; go to OUT.
  - If wait_cnt reaches TIMEOUT_CYCLES-1 with no completion: out_result=QNAN, out_nan=1, out_timeout=1, out_valid=1, go to OUT.
  - If completion and timeout fall in the same cycle, completion wins.
- OUT:
  - out_valid and all out_* fields are held stable until out_ready=1.
  - On out_valid&out_ready: out_valid=0, go to IDLE. in_ready rises the following cycle, so there is no same-cycle reissue.
- Latency: issue-accept to out_valid = EN_PULSE_CYCLES + divider latency + 1 cycle.
- div_ready or div_nan edges in IDLE or OUT are ignored. They are counted only for debug, with no effect on outputs.
- Reset mid-operation: immediate return to reset values. div_en drops asynchronously and the in-flight result is discarded.
- in_valid while busy is not accepted (in_ready=0). Upstream must hold its operands.

Optional Feature:
FP_DIV_ISSUER_BYPASS_EN
- Defined: operands are classified in IDLE. These cases skip the Divider entirely (div_en stays 0) and go straight to OUT on the next cycle:
  - NaN operand, 0/0, or Inf/Inf → QNAN, out_nan=1.
  - x/0 with x≠0, or Inf/finite → ±Inf (sign = XOR of operand signs).
  - 0/x or finite/Inf → ±0.
- Undefined: every op goes through the Divider. The classifier is not instantiated.

Decomposition:
- Package fp_div_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, OUT};
  - QNAN, POS_INF and SIGN_MASK constants;
  - field-extract functions for sign, exponent and mantissa.
- One sub-module, fp_special_classifier. It is combinational: it takes a/b and returns is_special and the special result/nan. It is instantiated only under FP_DIV_ISSUER_BYPASS_EN.

Test Plan:
- 40000000/3F800000 with a behavioural divider (Ready pulse 10 cycles after En) → div_en high exactly 2 cycles; out_result=40000000, out_nan=0, out_timeout=0.
- 40700000/3FC00000 with out_ready held low 5 cycles → out_valid and out_result=40200000 stable all 5 cycles; in_ready=0 until one cycle after the handshake.
- 00000000/00000000, model raises NaN without Ready → out_result=7FC00000, out_nan=1, out_timeout=0.
- Model never responds → out_valid rises exactly TIMEOUT_CYCLES cycles after div_en falls; out_result=7FC00000, out_timeout=1.
- Ready left high from the previous op, new op issued → no completion until a fresh Ready rising edge.
- Reset asserted in WAIT → div_en=0 and out_valid=0 immediately; after release the next op 3F800000/3F800000 returns 3F800000. Under BYPASS_EN: 40A00000/00000000 → 7F800000 with div_en never asserted.
